// File: rtl/line_fill_unit.sv
// Instruction-cache line refill engine: word-serial reads assembled into one line.
// Optional macro LINE_FILL_TIMEOUT_EN adds a per-word response timeout and fill_error_o.
module line_fill_unit #(
   parameter  int unsigned ByteOffsetBits = 4,
   parameter  int unsigned TimeoutCycles  = 255,
   localparam int unsigned NrWordsPerLine = (2**ByteOffsetBits) / 4,
   localparam int unsigned LineSize       = 32 * NrWordsPerLine
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                line_req_i,
   input  logic [31:0]         line_addr_i,
   output logic                line_valid_o,
   output logic [LineSize-1:0] line_data_o,
   output logic                word_req_o,
   output logic [31:0]         word_addr_o,
   input  logic                word_rvalid_i,
   input  logic [31:0]         word_rdata_i
`ifdef LINE_FILL_TIMEOUT_EN
   ,
   output logic                fill_error_o
`endif
);

   localparam int unsigned CntW = (NrWordsPerLine > 1) ? $clog2(NrWordsPerLine) : 1;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_RSP = 2'd1;
   localparam logic [1:0] DRAIN    = 2'd2;
   localparam logic [1:0] DONE     = 2'd3;

   logic [1:0]                 state_q;
   logic [CntW-1:0]            cnt_q;
   logic [31:ByteOffsetBits]   tag_q;
   logic [LineSize-1:0]        buf_q;
   logic [LineSize-1:0]        fill_line;
   logic                       line_abort;
   logic                       last_word;
   logic                       unused_offset;

   assign unused_offset = ^line_addr_i[ByteOffsetBits-1:0];

   always_comb begin
      fill_line                      = buf_q;
      fill_line[{cnt_q, 5'd0} +: 32] = word_rdata_i;
      line_abort = !line_req_i || (line_addr_i[31:ByteOffsetBits] != tag_q);
      last_word  = (cnt_q == CntW'(NrWordsPerLine - 1));
   end

`ifdef LINE_FILL_TIMEOUT_EN
   localparam int unsigned TmoW = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
   logic [TmoW-1:0] tmo_q;
`else
   localparam int unsigned UnusedTimeoutCycles = TimeoutCycles;
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         tag_q        <= '0;
         buf_q        <= '0;
         line_valid_o <= 1'b0;
         line_data_o  <= '0;
         word_req_o   <= 1'b0;
         word_addr_o  <= '0;
`ifdef LINE_FILL_TIMEOUT_EN
         fill_error_o <= 1'b0;
         tmo_q        <= '0;
`endif
      end else begin
         line_valid_o <= 1'b0;
         word_req_o   <= 1'b0;
`ifdef LINE_FILL_TIMEOUT_EN
         fill_error_o <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (line_req_i) begin
                  tag_q       <= line_addr_i[31:ByteOffsetBits];
                  cnt_q       <= '0;
                  word_req_o  <= 1'b1;
                  word_addr_o <= {line_addr_i[31:ByteOffsetBits], {ByteOffsetBits{1'b0}}};
                  state_q     <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               // Abort outranks a coinciding response: that word belongs to the stale line.
               if (line_abort) begin
                  state_q <= word_rvalid_i ? IDLE : DRAIN;
               end else if (word_rvalid_i) begin
                  buf_q <= fill_line;
                  if (last_word) begin
                     line_data_o  <= fill_line;
                     line_valid_o <= 1'b1;
                     state_q      <= DONE;
                  end else begin
                     cnt_q       <= cnt_q + CntW'(1);
                     word_req_o  <= 1'b1;
                     word_addr_o <= word_addr_o + 32'd4;
                  end
               end
            end
            DRAIN: begin
               if (word_rvalid_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
`ifdef LINE_FILL_TIMEOUT_EN
         // Counter value k means k cycles since the last word_req_o; later state_q write wins.
         if (state_q == WAIT_RSP || state_q == DRAIN) begin
            if (word_rvalid_i || (state_q == WAIT_RSP && line_abort)) begin
               tmo_q <= '0;
            end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
               tmo_q        <= '0;
               fill_error_o <= 1'b1;
               state_q      <= IDLE;
            end else begin
               tmo_q <= tmo_q + TmoW'(1);
            end
         end else begin
            tmo_q <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: randomized fills against a behavioural memory/line model.
module tb_line_fill_unit;
   localparam int unsigned NW = 4;

   logic         clk_i = 1'b0;
   logic         rstn_i;
   logic         line_req_i;
   logic [31:0]  line_addr_i;
   logic         line_valid_o;
   logic [127:0] line_data_o;
   logic         word_req_o;
   logic [31:0]  word_addr_o;
   logic         word_rvalid_i;
   logic [31:0]  word_rdata_i;
`ifdef LINE_FILL_TIMEOUT_EN
   logic         fill_error_o;
`endif

   line_fill_unit #(.ByteOffsetBits(4), .TimeoutCycles(16)) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .line_req_i   (line_req_i),
      .line_addr_i  (line_addr_i),
      .line_valid_o (line_valid_o),
      .line_data_o  (line_data_o),
      .word_req_o   (word_req_o),
      .word_addr_o  (word_addr_o),
      .word_rvalid_i(word_rvalid_i),
      .word_rdata_i (word_rdata_i)
`ifdef LINE_FILL_TIMEOUT_EN
      ,
      .fill_error_o (fill_error_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] a;
      int          due;
   } rsp_t;

   int unsigned  n_checks = 0;
   int unsigned  n_pass   = 0;
   int           cyc      = 0;
   rsp_t         pend[$];
   logic [31:0]  req_addrs[$];
   int           wreq_cnt, vcnt, vcyc, ecnt, ecyc, fcyc;
   logic [127:0] vdata;
   logic [127:0] last_line = '0;
   int           lat_mode = 1;
   bit           mute = 1'b0;
   bit           fixed_pat = 1'b0;
   logic [31:0]  salt = 32'h0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (fixed_pat) return 32'hA0 + ((a - 32'h1230) >> 2);
      return (a * 32'h9E3779B1) ^ salt;
   endfunction

   function automatic logic [127:0] exp_line(input logic [31:0] base);
      logic [127:0] r;
      for (int k = 0; k < NW; k++) r[32*k +: 32] = mem_word(base + 32'(4*k));
      return r;
   endfunction

   task automatic clr_mon();
      req_addrs.delete();
      wreq_cnt = 0; vcnt = 0; ecnt = 0; fcyc = 0;
   endtask

   // One clock: observe outputs just after the edge, then play the memory for this cycle.
   task automatic cycle();
      @(posedge clk_i);
      #1;
      cyc++;
      if (word_req_o) begin
         check("one_outstanding", 128'(pend.size()), 128'(0));
         req_addrs.push_back(word_addr_o);
         wreq_cnt++;
         if (wreq_cnt == 1) fcyc = cyc;
         if (!mute) begin
            rsp_t r;
            r.a   = word_addr_o;
            r.due = cyc + ((lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode);
            pend.push_back(r);
         end
      end
      if (line_valid_o) begin
         vcnt++; vcyc = cyc; vdata = line_data_o;
      end
`ifdef LINE_FILL_TIMEOUT_EN
      if (fill_error_o) begin
         ecnt++; ecyc = cyc;
      end
`endif
      word_rvalid_i = 1'b0;
      word_rdata_i  = $urandom;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         word_rvalid_i = 1'b1;
         word_rdata_i  = mem_word(pend[0].a);
         void'(pend.pop_front());
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic fill(input logic [31:0] addr, input int lat, input int abort_k,
                       input logic [31:0] new_addr, input bit on_rvalid);
      int          t0, prefix, idx;
      bit          aborted;
      logic [31:0] base, obase, got;
      lat_mode = lat;
      clr_mon();
      aborted = 1'b0; prefix = 0;
      line_addr_i = addr;
      line_req_i  = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 300 && vcnt == 0; i++) begin
         cycle();
         if (i == 0) check("data_hold", line_data_o, last_line);
         if (abort_k > 0 && !aborted && wreq_cnt == abort_k &&
             (on_rvalid ? word_rvalid_i : word_req_o)) begin
            line_addr_i = new_addr;
            aborted = 1'b1;
            prefix  = wreq_cnt;
         end
      end
      line_req_i = 1'b0;
      check("valid_seen", 128'(vcnt > 0), 128'(1));
      idle(3);
      obase = addr & ~32'hF;
      base  = (aborted ? new_addr : addr) & ~32'hF;
      check("valid_count", 128'(vcnt), 128'(1));
      check("req_count", 128'(wreq_cnt), 128'(prefix + NW));
      for (int k = 0; k < prefix; k++) check("old_word_addr", req_addrs[k], obase + 32'(4*k));
      for (int k = 0; k < NW; k++) begin
         idx = prefix + k;
         got = (idx < req_addrs.size()) ? req_addrs[idx] : 32'hxxxx_xxxx;
         check("word_addr", got, base + 32'(4*k));
      end
      check("line_data", vdata, exp_line(base));
      check("data_stable", line_data_o, exp_line(base));
      if (lat == 1 && !aborted) check("latency", 128'(vcyc - t0), 128'(9));
      last_line = exp_line(base);
   endtask

   task automatic drop(input logic [31:0] addr, input int lat, input int k);
      bit hit;
      lat_mode = lat;
      clr_mon();
      hit = 1'b0;
      line_addr_i = addr;
      line_req_i  = 1'b1;
      for (int i = 0; i < 200 && !hit; i++) begin
         cycle();
         if (wreq_cnt == k && word_req_o) hit = 1'b1;
      end
      line_req_i = 1'b0;
      check("drop_reached", 128'(hit), 128'(1));
      idle(10);
      check("drop_no_valid", 128'(vcnt), 128'(0));
      check("drop_req_count", 128'(wreq_cnt), 128'(k));
      check("drop_drained", 128'(pend.size()), 128'(0));
   endtask

   task automatic reset_mid();
      bit hit;
      lat_mode = 3;
      clr_mon();
      hit = 1'b0;
      line_addr_i = 32'h0000_4440;
      line_req_i  = 1'b1;
      for (int i = 0; i < 200 && !hit; i++) begin
         cycle();
         if (wreq_cnt == 2 && word_req_o) hit = 1'b1;
      end
      check("rst_reached", 128'(hit), 128'(1));
      rstn_i = 1'b0;
      line_req_i = 1'b0;
      cycle();
      check("rst_valid", 128'(line_valid_o), 128'(0));
      check("rst_data", line_data_o, 128'(0));
      check("rst_word_req", 128'(word_req_o), 128'(0));
      check("rst_word_addr", 128'(word_addr_o), 128'(0));
      rstn_i = 1'b1;
      last_line = '0;
      idle(6);
      check("rst_late_rsp_no_valid", 128'(vcnt), 128'(0));
      check("rst_no_more_req", 128'(wreq_cnt), 128'(2));
      check("rst_drained", 128'(pend.size()), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, na;
      int          ak;
      rstn_i = 1'b0; line_req_i = 1'b0; line_addr_i = '0;
      word_rvalid_i = 1'b0; word_rdata_i = '0;
      idle(3);
      check("reset_valid", 128'(line_valid_o), 128'(0));
      check("reset_data", line_data_o, 128'(0));
      check("reset_word_req", 128'(word_req_o), 128'(0));
      check("reset_word_addr", 128'(word_addr_o), 128'(0));
`ifdef LINE_FILL_TIMEOUT_EN
      check("reset_error", 128'(fill_error_o), 128'(0));
`endif
      rstn_i = 1'b1;
      idle(2);

      fixed_pat = 1'b1;
      fill(32'h0000_1234, 1, 0, 32'h0, 1'b0);
      check("fixed_line", last_line, 128'h000000A3_000000A2_000000A1_000000A0);
      fixed_pat = 1'b0;
      salt = $urandom;

      fill(32'h0000_5678, 3, 0, 32'h0, 1'b0);
      drop(32'h0000_1230, 1, 3);
      fill(32'h0000_1230, 1, 3, 32'h0000_2000, 1'b0);
      fill(32'h0000_1230, 2, 2, 32'h0000_2000, 1'b1);
      reset_mid();
      fill(32'h0000_7770, 1, 0, 32'h0, 1'b0);

`ifdef LINE_FILL_TIMEOUT_EN
      mute = 1'b1;
      pend.delete();
      clr_mon();
      line_addr_i = 32'h0000_9000;
      line_req_i  = 1'b1;
      for (int i = 0; i < 100 && ecnt == 0; i++) begin
         cycle();
         if (ecnt > 0) line_req_i = 1'b0;
      end
      line_req_i = 1'b0;
      idle(20);
      check("tmo_error_count", 128'(ecnt), 128'(1));
      check("tmo_error_time", 128'(ecyc - fcyc), 128'(16));
      check("tmo_no_valid", 128'(vcnt), 128'(0));
      check("tmo_req_count", 128'(wreq_cnt), 128'(1));
      mute = 1'b0;
      fill(32'h0000_9000, 1, 0, 32'h0, 1'b0);
`endif

      for (int n = 0; n < 40; n++) begin
         a  = $urandom;
         ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         na = $urandom;
         if (na[31:4] == a[31:4]) na[31] = ~na[31];
         fill(a, int'($urandom_range(0, 3)), ak, na, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
